collatz_core: RTL and testbench

COLLATZ_CORE -- requirements
Module: collatz_core

---
 rtl/collatz_pkg.sv | 13 +
 rtl/collatz_step.sv | 28 ++
 rtl/collatz_core.sv | 105 ++++++++++
 tb/tb_collatz_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared defaults and FSM encoding for the Collatz orbit engine.
package collatz_pkg;

    localparam int DEFAULT_BITS     = 32;
    localparam int DEFAULT_ACC_BITS = 64;
    localparam int DEFAULT_LEN_BITS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: halve an even iterate, or form 3n+1 for an odd one and flag overflow.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int ACC_BITS = DEFAULT_ACC_BITS
) (
    input  logic [ACC_BITS-1:0] n,
    output logic [ACC_BITS-1:0] next_n,
    output logic                ovf
);

    logic [ACC_BITS+1:0] n_ext;
    logic [ACC_BITS+1:0] triple;

    // Two guard bits catch every 3n+1 that no longer fits the iterate register.
    assign n_ext  = {2'b00, n};
    assign triple = (n_ext << 1) + n_ext + (ACC_BITS+2)'(1);

    always_comb begin
        next_n = n >> 1;
        ovf    = 1'b0;
        if (n[0]) begin
            next_n = triple[ACC_BITS-1:0];
            ovf    = |triple[ACC_BITS+1:ACC_BITS];
        end
    end

endmodule

// File: rtl/collatz_core.sv
// Iterates the Collatz map from a seed, tracking orbit length and the largest value reached.
module collatz_core
    import collatz_pkg::*;
#(
    parameter int BITS     = DEFAULT_BITS,
    parameter int ACC_BITS = DEFAULT_ACC_BITS,
    parameter int LEN_BITS = DEFAULT_LEN_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BITS-1:0]     seed,
    output logic                busy,
    output logic                done,
    output logic [LEN_BITS-1:0] orbit_len,
    output logic [ACC_BITS-1:0] path_rec,
    output logic                overflow,
    output logic                err_zero
);

    localparam logic [LEN_BITS-1:0] LEN_MAX = {LEN_BITS{1'b1}};

    state_t              state, state_nxt;
    logic [ACC_BITS-1:0] n, n_nxt;
    logic [ACC_BITS-1:0] rec_nxt;
    logic [LEN_BITS-1:0] len_nxt;
    logic                ovf_nxt, ez_nxt, done_nxt;
    logic [ACC_BITS-1:0] step_n;
    logic                step_ovf;

    collatz_step #(.ACC_BITS(ACC_BITS)) u_step (
        .n      (n),
        .next_n (step_n),
        .ovf    (step_ovf)
    );

    assign busy = (state == RUN);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        rec_nxt   = path_rec;
        len_nxt   = orbit_len;
        ovf_nxt   = overflow;
        ez_nxt    = err_zero;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    n_nxt     = {{(ACC_BITS-BITS){1'b0}}, seed};
                    rec_nxt   = {{(ACC_BITS-BITS){1'b0}}, seed};
                    len_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    ez_nxt    = 1'b0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A zero seed never converges; it is reported and dropped on the first cycle.
                if (n == '0) begin
                    ez_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (n == ACC_BITS'(1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (step_ovf || orbit_len == LEN_MAX) begin
                    ovf_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    n_nxt   = step_n;
                    len_nxt = orbit_len + LEN_BITS'(1);
                    if (step_n > path_rec) begin
                        rec_nxt = step_n;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and clears every register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            path_rec  <= '0;
            orbit_len <= '0;
            overflow  <= 1'b0;
            err_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            n         <= n_nxt;
            path_rec  <= rec_nxt;
            orbit_len <= len_nxt;
            overflow  <= ovf_nxt;
            err_zero  <= ez_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_collatz_core.sv
// Scoreboard bench: three collatz_core configurations share stimulus, each with its own expectation queue.
module tb_collatz_core;

    typedef struct {
        logic [15:0] len;
        logic [63:0] rec;
        logic        ovf;
        logic        ez;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [31:0] seed = '0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Default configuration.
    logic        busy_m, done_m, ovf_m, ez_m;
    logic [15:0] len_m;
    logic [63:0] rec_m;
    // Narrow iterate: 3n+1 overflows quickly.
    logic        busy_a, done_a, ovf_a, ez_a;
    logic [15:0] len_a;
    logic [7:0]  rec_a;
    // Short step counter: length limit trips on long orbits.
    logic        busy_l, done_l, ovf_l, ez_l;
    logic [3:0]  len_l;
    logic [63:0] rec_l;

    exp_t q_m[$];
    exp_t q_a[$];
    exp_t q_l[$];

    collatz_core u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy_m), .done(done_m), .orbit_len(len_m), .path_rec(rec_m),
        .overflow(ovf_m), .err_zero(ez_m)
    );

    collatz_core #(.BITS(7), .ACC_BITS(8)) u_acc8 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed[6:0]),
        .busy(busy_a), .done(done_a), .orbit_len(len_a), .path_rec(rec_a),
        .overflow(ovf_a), .err_zero(ez_a)
    );

    collatz_core #(.LEN_BITS(4)) u_len4 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy_l), .done(done_l), .orbit_len(len_l), .path_rec(rec_l),
        .overflow(ovf_l), .err_zero(ez_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Hand-computed results; inst 0 = default, 1 = 8-bit iterate, 2 = 4-bit length.
    function automatic exp_t expect_for(input int inst, input int s, input int e0);
        exp_t e;
        e.ovf = 1'b0;
        e.ez  = 1'b0;
        case (s)
            27: begin
                if (inst == 0) begin
                    e.len = 16'd111; e.rec = 64'd9232; e.cyc = e0 + 112;
                end else if (inst == 1) begin
                    e.len = 16'd11; e.rec = 64'd214; e.ovf = 1'b1; e.cyc = e0 + 12;
                end else begin
                    e.len = 16'd15; e.rec = 64'd484; e.ovf = 1'b1; e.cyc = e0 + 16;
                end
            end
            6:       begin e.len = 16'd8; e.rec = 64'd16; e.cyc = e0 + 9; end
            1:       begin e.len = 16'd0; e.rec = 64'd1;  e.cyc = e0 + 1; end
            default: begin e.len = 16'd0; e.rec = 64'd0;  e.ez = 1'b1; e.cyc = e0 + 1; end
        endcase
        return e;
    endfunction

    task automatic compare(input string nm, input exp_t e, input logic [15:0] len,
                           input logic [63:0] rec, input logic ovf, input logic ez);
        check({nm, " orbit_len"}, 64'(len), 64'(e.len));
        check({nm, " path_rec"},  rec, e.rec);
        check({nm, " overflow"},  64'(ovf), 64'(e.ovf));
        check({nm, " err_zero"},  64'(ez), 64'(e.ez));
        check({nm, " done_cycle"}, 64'(cyc), 64'(e.cyc));
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s unexpected done at cycle %0d", nm, cyc);
    endtask

    // Monitors: pop an expectation whenever a done pulse is visible.
    always @(negedge clk) begin
        if (rst_n && done_m) begin
            if (q_m.size() == 0) unexpected("main");
            else compare("main", q_m.pop_front(), len_m, rec_m, ovf_m, ez_m);
        end
        if (rst_n && done_a) begin
            if (q_a.size() == 0) unexpected("acc8");
            else compare("acc8", q_a.pop_front(), len_a, 64'(rec_a), ovf_a, ez_a);
        end
        if (rst_n && done_l) begin
            if (q_l.size() == 0) unexpected("len4");
            else compare("len4", q_l.pop_front(), 16'(len_l), rec_l, ovf_l, ez_l);
        end
    end

    task automatic push_all(input int s, input int e0, input bit with_main);
        if (with_main) q_m.push_back(expect_for(0, s, e0));
        q_a.push_back(expect_for(1, s, e0));
        q_l.push_back(expect_for(2, s, e0));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy_m || busy_a || busy_l) && k < budget);
        if (busy_m || busy_a || busy_l) begin
            checks++;
            errors++;
            $display("FAIL wait_idle still busy after %0d cycles", budget);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input int s);
        @(negedge clk);
        seed  = 32'(s);
        start = 1'b1;
        push_all(s, cyc + 1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_idle(400);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " busy"},      64'(busy_m), 64'd0);
        check({nm, " done"},      64'(done_m), 64'd0);
        check({nm, " orbit_len"}, 64'(len_m),  64'd0);
        check({nm, " path_rec"},  rec_m,       64'd0);
        check({nm, " overflow"},  64'(ovf_m),  64'd0);
        check({nm, " err_zero"},  64'(ez_m),   64'd0);
        check({nm, " acc8_len"},  64'(len_a),  64'd0);
        check({nm, " len4_rec"},  rec_l,       64'd0);
    endtask

    initial begin
        int e0;
        // Reset wins over a simultaneous start request.
        seed  = 32'd5;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;

        issue(1);
        issue(0);
        issue(6);
        issue(27);

        // Results persist while idle.
        repeat (3) @(negedge clk);
        check("hold orbit_len", 64'(len_m), 64'd111);
        check("hold path_rec",  rec_m,      64'd9232);
        check("hold busy",      64'(busy_m), 64'd0);

        // Restart attempt mid-run is ignored; reset aborts without a done pulse.
        @(negedge clk);
        seed  = 32'd27;
        start = 1'b1;
        e0    = cyc + 1;
        push_all(27, e0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 4);
        seed  = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort busy_after_restart", 64'(busy_m), 64'd1);
        wait_until(e0 + 49);
        check("abort busy_before_reset", 64'(busy_m), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("abort");
        rst_n = 1'b1;

        // Start held high: back-to-back runs ten cycles apart.
        @(negedge clk);
        seed  = 32'd6;
        start = 1'b1;
        e0    = cyc + 1;
        push_all(6, e0, 1'b1);
        push_all(6, e0 + 10, 1'b1);
        wait_until(e0 + 19);
        start = 1'b0;
        wait_idle(100);
        repeat (2) @(negedge clk);

        check("main pending", 64'(q_m.size()), 64'd0);
        check("acc8 pending", 64'(q_a.size()), 64'd0);
        check("len4 pending", 64'(q_l.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
